// File: rtl/jsq_pkg.sv
// Shared types for the jsq counter scheduler family:
// FSM state encoding, start-mode codes and timer sizing.
package jsq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE,
        ST_ERR
    } jsq_sched_st_t;

    localparam logic JSQ_MODE_EN1 = 1'b0;
    localparam logic JSQ_MODE_EN2 = 1'b1;

    function automatic int jsq_tmr_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/jsq_rr_pick.sv
// Combinational round-robin picker: first set req bit
// searching upward from ptr+1, wrapping modulo N_REQ.
module jsq_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW:0] w_cand;

    always_comb begin
        sel    = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            // ptr+i never exceeds 2*N_REQ-1, so one subtract wraps it
            w_cand = {1'b0, ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N_REQ))
                w_cand = w_cand - (IW+1)'(N_REQ);
            if (!valid && req[w_cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[IW-1:0];
            end
        end
        sel = valid ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/jsq_rr_sched.sv
// Round-robin owner of one jsq pulse counter: issues a start
// pulse for the winner, tracks dout to completion or timeout.
module jsq_rr_sched
    import jsq_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mode,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    output logic             busy,
    output logic             res_en1,
    output logic             res_en2,
    input  logic             res_dout
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = jsq_tmr_w(TIMEOUT);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

    jsq_sched_st_t    r_state;
    jsq_sched_st_t    w_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_w;
    logic [N_REQ-1:0] r_gnt;
    logic             r_mode;
    logic [TW-1:0]    r_tmr;
    logic             w_tmo;
    logic [N_REQ-1:0] w_sel;
    logic [IW-1:0]    w_idx;
    logic             w_valid;

    jsq_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .sel  (w_sel),
        .idx  (w_idx),
        .valid(w_valid)
    );

    assign w_tmo = (r_tmr == TMR_MAX);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_valid && !res_dout)
                    w_nxt = ST_ISSUE;
            ST_ISSUE:
                w_nxt = ST_WAIT_HI;
            ST_WAIT_HI:
                if (res_dout)
                    w_nxt = ST_WAIT_LO;
                else if (w_tmo)
                    w_nxt = ST_ERR;
            ST_WAIT_LO:
                if (!res_dout)
                    w_nxt = ST_DONE;
                else if (w_tmo)
                    w_nxt = ST_ERR;
            default:
                w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= IW'(N_REQ - 1);
            r_w     <= '0;
            r_gnt   <= '0;
            r_mode  <= JSQ_MODE_EN1;
            r_tmr   <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == ST_IDLE && w_nxt == ST_ISSUE) begin
                r_w    <= w_idx;
                r_gnt  <= w_sel;
                r_mode <= |(mode & w_sel);
            end
            if (r_state == ST_DONE || r_state == ST_ERR)
                r_ptr <= r_w;
            // any state change restarts the wait budget
            if (w_nxt != r_state)
                r_tmr <= '0;
            else if (!w_tmo)
                r_tmr <= r_tmr + TW'(1);
        end
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        err     = '0;
        busy    = 1'b0;
        res_en1 = 1'b0;
        res_en2 = 1'b0;
        unique case (r_state)
            ST_IDLE: ;
            ST_ISSUE: begin
                gnt     = r_gnt;
                busy    = 1'b1;
                res_en1 = (r_mode == JSQ_MODE_EN1);
                res_en2 = (r_mode == JSQ_MODE_EN2);
            end
            ST_DONE: begin
                gnt  = r_gnt;
                done = r_gnt;
                busy = 1'b1;
            end
            ST_ERR: begin
                gnt  = r_gnt;
                err  = r_gnt;
                busy = 1'b1;
            end
            default: begin
                gnt  = r_gnt;
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/jsq_rr_sched.md
# jsq_rr_sched

Round-robin scheduler that shares one pulse-counter resource (the `jsq` counter family) between `N_REQ` requesters. It arbitrates pending requests and issues a one-cycle start pulse on the resource's `en1` or `en2` input, chosen by the winner's mode bit. It then tracks the resource's `dout` busy window to completion and reports done or timeout back to the winner. It sits between the requesting control blocks and a single counter instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `TIMEOUT`, 64, max cycles waited in each WAIT state before abort (≥2)

Ports:
- `clk` in 1, single clock; everything is on the rising edge
- `rst_n` in 1, reset, synchronous and active-low
- `req` in `N_REQ`, level request per requester; held until `done`/`err`
- `mode` in `N_REQ`, per-requester start select: 0 → `res_en1`, 1 → `res_en2`
- `gnt` out `N_REQ`, one-hot grant; high from ISSUE through DONE/ERR inclusive
- `done` out `N_REQ`, one-cycle completion pulse to the winner
- `err` out `N_REQ`, one-cycle timeout pulse to the winner
- `busy` out 1, high whenever state ≠ IDLE
- `res_en1` out 1, start pulse to resource, mode 0
- `res_en2` out 1, start pulse to resource, mode 1
- `res_dout` in 1, resource activity: high while the counter is running

## Operation
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE, ERR.
- **IDLE:** arbitrates when `|req` and `res_dout`==0.
  - The winner is the first set `req` bit searching upward from `ptr+1` (mod `N_REQ`).
  - Register winner index `w` and `mode[w]`, then go to ISSUE.
- **ISSUE:** lasts exactly 1 cycle.
  - Drive `res_en1` (mode 0) or `res_en2` (mode 1) high.
  - Go to WAIT_HI.
- **WAIT_HI:** on sampled `res_dout`==1, go to WAIT_LO. On timer==`TIMEOUT`, go to ERR.
- **WAIT_LO:** on sampled `res_dout`==0, go to DONE. On timer==`TIMEOUT`, go to ERR.
- **DONE:** `done[w]`=1 for 1 cycle, `ptr`←`w`, then IDLE.
- **ERR:** `err[w]`=1 for 1 cycle, `ptr`←`w`, then IDLE.
- Timer: width `$clog2(TIMEOUT+1)`. Cleared on entry to WAIT_HI and WAIT_LO; increments every cycle in those states; saturates.
- `gnt[w]`=1 in ISSUE, WAIT_HI, WAIT_LO, DONE and ERR; 0 in IDLE.
- `req[w]` dropping mid-operation does not abort. The sequence runs to DONE/ERR and still pulses `done`/`err`.
- `mode` is sampled only at arbitration; later changes are ignored.
- `res_en1` and `res_en2` are never high together and are never high outside ISSUE.
- A timeout in WAIT_LO leaves the resource running. IDLE then withholds arbitration until `res_dout`==0.

## Timing
- Reset (`rst_n`==0 at an edge):
  - State is IDLE; `ptr`=`N_REQ`-1, so requester 0 has first priority.
  - `gnt`, `done`, `err`, `busy`, `res_en1`, `res_en2` are all 0 the following cycle.
- Reset mid-operation: same as above; the in-flight request gets neither `done` nor `err`.
- All outputs are registered or decoded from registered state only. No combinational path from `req` or `res_dout` to any output.
- Request latency:
  - `req` high and sampled in IDLE at edge t → ISSUE at t+1, so `gnt` and the start pulse are visible in cycle t+1.
  - WAIT_HI from t+2.
- Completion: first sampled `res_dout`==0 in WAIT_LO at edge u → `done` high in cycle u+1 → IDLE at u+2.
- Back-to-back: the minimum IDLE dwell is 1 cycle. The next ISSUE is 2 cycles after DONE.
- Simultaneous requests are resolved in a single IDLE cycle. Fairness: every requester is served within `N_REQ` grants.

## Structure
- Package `jsq_pkg` holds:
  - the state enum `jsq_sched_st_t`;
  - the mode constants `JSQ_MODE_EN1`=0 and `JSQ_MODE_EN2`=1;
  - a function `jsq_tmr_w(TIMEOUT)`.
- Sub-module `jsq_rr_pick` is purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `sel`, index `idx`, `valid`.
  - It is reused by other shared-resource schedulers.
- Top level holds the FSM, timer, registered winner/mode, and output decode.

## Test plan
The bench model of the resource raises `dout` 2 cycles after a start pulse and holds it for 10 cycles, unless stated otherwise.
- Single request:
  - Stimulus: `req`=0001, `mode[0]`=1.
  - Required: `gnt`=0001 and a `res_en2` pulse in the cycle after sampling, no `res_en1`.
  - Required: `done[0]` one cycle after `dout` falls, `busy` low the cycle after.
- Fairness:
  - Stimulus: `req`=1111 held, with reset `ptr`=3.
  - Required: grant order 0,1,2,3,0.
  - Required: never two bits in `gnt`; exactly one `done` per grant.
- No-response timeout:
  - Stimulus: the model never raises `dout`.
  - Required: `err[w]` pulses `TIMEOUT`+1 cycles after entering WAIT_HI; no `done`; `ptr` advances.
- Stuck-high timeout:
  - Stimulus: the model holds `dout` high for 200 cycles with `TIMEOUT`=64.
  - Required: `err` pulses.
  - Required: no new ISSUE while `dout`=1, even with `req`=0010; that grant follows after `dout` falls.
- Drop request and reset:
  - Stimulus: `req[2]` drops in WAIT_HI.
  - Required: `done[2]` still pulses.
  - Stimulus: `rst_n` asserted in WAIT_LO.
  - Required: all outputs 0 next cycle, no `done`.
